// File: rtl/snowbro2_pkg.sv
// Shared constants and types for the Snow Bros 2 ROM download loader.
// Region bounds are byte offsets measured from the end of the stream header.
package snowbro2_pkg;

    localparam int unsigned HDR_LEN  = 16;
    localparam int unsigned PRG_END  = 32'h0008_0000;
    localparam int unsigned PCM_END  = 32'h0010_0000;
    localparam int unsigned GFX_END  = 32'h0050_0000;

    localparam int unsigned IOCTL_AW = 26;
    localparam int unsigned IOCTL_DW = 8;
    localparam int unsigned PROG_AW  = 22;
    localparam int unsigned PROG_DW  = 16;
    localparam int unsigned BA_W     = 2;
    localparam int unsigned MASK_W   = 2;

    localparam logic [BA_W-1:0] BA_PRG = 2'd0;
    localparam logic [BA_W-1:0] BA_PCM = 2'd1;
    localparam logic [BA_W-1:0] BA_GFX = 2'd2;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_WRITE = 1'b1;

    // One SDRAM byte-lane write, as queued and as presented on PROG_*.
    typedef struct packed {
        logic [BA_W-1:0]    ba;
        logic [PROG_AW-1:0] addr;
        logic [PROG_DW-1:0] data;
        logic [MASK_W-1:0]  mask;
    } prog_req_t;

    localparam prog_req_t PROG_REQ_RST = '{ba: BA_PRG, addr: '0, data: '0, mask: 2'b11};

    // Big-endian lanes: even bytes go to the upper half, so the lower lane is masked.
    function automatic logic [MASK_W-1:0] lane_mask(input logic odd);
        return odd ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/snowbro2_loader_fifo.sv
// Two-entry FIFO of pending SDRAM byte writes between the stream and the write FSM.
// A push into a full FIFO is refused even if a pop happens in the same cycle.
module snowbro2_loader_fifo
    import snowbro2_pkg::*;
(
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      push_i,
    input  prog_req_t data_i,
    input  logic      pop_i,
    output prog_req_t data_o,
    output logic      full_o,
    output logic      empty_o
);

    localparam logic [1:0] DEPTH = 2'd2;

    prog_req_t  mem_q [2];
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] count_q;
    logic       do_push;
    logic       do_pop;

    assign full_o  = (count_q == DEPTH);
    assign empty_o = (count_q == 2'd0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/snowbro2_prog_loader.sv
// Converts the ioctl ROM byte stream into banked 16-bit SDRAM lane writes,
// buffering up to two bytes while the SDRAM controller completes a write.
module snowbro2_prog_loader #(
    parameter int unsigned HDR_LEN = snowbro2_pkg::HDR_LEN,
    parameter int unsigned PRG_END = snowbro2_pkg::PRG_END,
    parameter int unsigned PCM_END = snowbro2_pkg::PCM_END,
    parameter int unsigned GFX_END = snowbro2_pkg::GFX_END
) (
    input  logic                                 CLK,
    input  logic                                 RESET,
    input  logic                                 DOWNLOADING,
    input  logic [snowbro2_pkg::IOCTL_AW-1:0]    IOCTL_ADDR,
    input  logic [snowbro2_pkg::IOCTL_DW-1:0]    IOCTL_DOUT,
    input  logic                                 IOCTL_WR,
    output logic [snowbro2_pkg::PROG_AW-1:0]     PROG_ADDR,
    output logic [snowbro2_pkg::PROG_DW-1:0]     PROG_DATA,
    output logic [snowbro2_pkg::MASK_W-1:0]      PROG_MASK,
    output logic [snowbro2_pkg::BA_W-1:0]        PROG_BA,
    output logic                                 PROG_WE,
    input  logic                                 PROG_RDY,
    output logic                                 DWNLD_BUSY,
    output logic [7:0]                           GAME,
    output logic                                 OVERFLOW
);

    import snowbro2_pkg::*;

    localparam logic [IOCTL_AW-1:0] HDR_W = IOCTL_AW'(HDR_LEN);
    localparam logic [IOCTL_AW-1:0] PRG_W = IOCTL_AW'(PRG_END);
    localparam logic [IOCTL_AW-1:0] PCM_W = IOCTL_AW'(PCM_END);
    localparam logic [IOCTL_AW-1:0] GFX_W = IOCTL_AW'(GFX_END);

    logic [IOCTL_AW-1:0] off_c;
    logic [IOCTL_AW-1:0] rel_c;
    logic                keep_c;
    logic                strobe_c;
    logic                push_c;
    logic                pop_c;
    prog_req_t           req_c;

    prog_req_t           fifo_head;
    logic                fifo_full;
    logic                fifo_empty;

    logic [0:0]          state_q, state_d;
    logic                prog_we_q, prog_we_d;
    prog_req_t           prog_q, prog_d;
    logic [7:0]          game_q;
    logic                overflow_q;
    logic                dl_q;

    assign strobe_c = DOWNLOADING && IOCTL_WR;

    // Region decoder: header bytes and anything past the GFX region are not written.
    always_comb begin
        off_c  = IOCTL_ADDR - HDR_W;
        rel_c  = off_c;
        keep_c = 1'b1;
        req_c  = PROG_REQ_RST;
        if (off_c < PRG_W) begin
            req_c.ba = BA_PRG;
        end else if (off_c < PCM_W) begin
            req_c.ba = BA_PCM;
            rel_c    = off_c - PRG_W;
        end else if (off_c < GFX_W) begin
            req_c.ba = BA_GFX;
            rel_c    = off_c - PCM_W;
        end else begin
            keep_c = 1'b0;
        end
        if (IOCTL_ADDR < HDR_W) begin
            keep_c = 1'b0;
        end
        req_c.addr = PROG_AW'(rel_c >> 1);
        req_c.data = {IOCTL_DOUT, IOCTL_DOUT};
        req_c.mask = lane_mask(off_c[0]);
    end

    assign push_c = strobe_c && keep_c;

    snowbro2_loader_fifo u_fifo (
        .clk_i   (CLK),
        .rst_i   (RESET),
        .push_i  (push_c),
        .data_i  (req_c),
        .pop_i   (pop_c),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Write FSM: present one queued byte and hold it until the controller acknowledges.
    always_comb begin
        state_d   = state_q;
        prog_we_d = prog_we_q;
        prog_d    = prog_q;
        pop_c     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop_c     = 1'b1;
                    prog_d    = fifo_head;
                    prog_we_d = 1'b1;
                    state_d   = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (PROG_RDY) begin
                    prog_we_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                prog_we_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            prog_we_q <= 1'b0;
            prog_q    <= PROG_REQ_RST;
        end else begin
            state_q   <= state_d;
            prog_we_q <= prog_we_d;
            prog_q    <= prog_d;
        end
    end

    // Game id capture and sticky drop flag; a new download clears the flag.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            game_q     <= 8'h00;
            overflow_q <= 1'b0;
            dl_q       <= 1'b0;
        end else begin
            dl_q <= DOWNLOADING;
            if (strobe_c && (IOCTL_ADDR == '0)) begin
                game_q <= IOCTL_DOUT;
            end
            if (DOWNLOADING && !dl_q) begin
                overflow_q <= 1'b0;
            end
            if (push_c && fifo_full) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign PROG_WE    = prog_we_q;
    assign PROG_ADDR  = prog_q.addr;
    assign PROG_DATA  = prog_q.data;
    assign PROG_MASK  = prog_q.mask;
    assign PROG_BA    = prog_q.ba;
    assign GAME       = game_q;
    assign OVERFLOW   = overflow_q;
    assign DWNLD_BUSY = DOWNLOADING || !fifo_empty || (state_q == ST_WRITE);

endmodule

// File: doc/snowbro2_prog_loader.md
SNOWBRO2_PROG_LOADER -- requirements
Module: snowbro2_prog_loader

Interface
REQ-001 Parameters SHALL be: HDR_LEN, 16, header byte count; PRG_END, 0x080000, end of the 68K program region; PCM_END, 0x100000, end of the PCM region; GFX_END, 0x500000, end of the GFX region. All region offsets are relative to the end of the header.
REQ-002 CLK  in  1  clock; the single clock; all logic runs in the CLK domain.
REQ-003 RESET  in  1  reset, synchronous, active-high.
REQ-004 DOWNLOADING  in  1  high while the ROM stream is being delivered.
REQ-005 IOCTL_ADDR  in  26  byte address in the stream; IOCTL_DOUT  in  8  byte data; IOCTL_WR  in  1  one-cycle byte strobe.
REQ-006 PROG_ADDR  out  22  word address within the target bank; PROG_DATA  out  16  write data; PROG_MASK  out  2  lane mask, 1 = lane masked; PROG_BA  out  2  target bank.
REQ-007 PROG_WE  out  1  write request; PROG_RDY  in  1  one-cycle write-complete acknowledge from the SDRAM controller.
REQ-008 DWNLD_BUSY  out  1  loader still active; GAME  out  8  game id; OVERFLOW  out  1  sticky flag, a byte was dropped.

Function
REQ-009 A header byte (IOCTL_ADDR < HDR_LEN) SHALL NOT generate a write; byte 0 SHALL load GAME on the cycle after its IOCTL_WR.
REQ-010 A payload byte at offset o = IOCTL_ADDR - HDR_LEN SHALL be routed by region:
- o < PRG_END: bank 0, base 0.
- PRG_END <= o < PCM_END: bank 1, base PRG_END.
- PCM_END <= o < GFX_END: bank 2, base PCM_END.
- o >= GFX_END: discarded silently.
REQ-011 PROG_ADDR SHALL equal (o - base) >> 1, truncated to 22 bits.
REQ-012 Byte lanes SHALL be big-endian: an even o gives mask 2'b01 with the byte on PROG_DATA[15:8]. An odd o gives mask 2'b10 with the byte on PROG_DATA[7:0]. The byte SHALL be replicated on both halves of PROG_DATA.
REQ-013 Accepted bytes SHALL enter a 2-entry FIFO of {ba, addr, data, mask}. IOCTL_WR with the FIFO full SHALL drop the byte and set OVERFLOW. IOCTL_WR outside DOWNLOADING SHALL be ignored.
REQ-014 The write FSM SHALL have two states:
- IDLE -> WRITE when the FIFO is non-empty: pop the FIFO head into the PROG_* registers and assert PROG_WE.
- WRITE -> IDLE on PROG_RDY: deassert PROG_WE.
REQ-015 Write latency: a byte written into an empty FIFO with the FSM in IDLE SHALL drive PROG_WE high 2 cycles after its IOCTL_WR.
REQ-016 PROG_WE SHALL stay high and PROG_ADDR, PROG_DATA, PROG_MASK and PROG_BA SHALL stay stable until PROG_RDY.
REQ-017 A push and a pop in the same cycle SHALL both take effect. A push into a full FIFO is not accepted even when a pop occurs in that cycle.
REQ-018 DWNLD_BUSY SHALL equal DOWNLOADING OR (FIFO non-empty) OR (state == WRITE). After DOWNLOADING falls, pending entries SHALL drain before DWNLD_BUSY drops.
REQ-019 A rising edge of DOWNLOADING SHALL clear OVERFLOW. GAME SHALL hold its value after the download ends.

Reset
REQ-020 RESET SHALL force the following, overriding any other event in the same cycle:
- state = IDLE, FIFO empty;
- PROG_WE = 0, PROG_ADDR = 0, PROG_DATA = 0, PROG_MASK = 2'b11, PROG_BA = 0;
- GAME = 0, OVERFLOW = 0.
REQ-021 RESET during WRITE SHALL abandon the pending write; after release, no PROG_WE SHALL occur for that write.

Structure
REQ-022 Region bounds, HDR_LEN, the bank ids (PRG = 0, PCM = 1, GFX = 2) and the FSM state encoding SHALL live in a shared package, snowbro2_pkg.
REQ-023 The FIFO SHALL be one sub-module, snowbro2_loader_fifo (depth 2, with full and empty outputs). The region decoder SHALL be inline combinational logic.

Verification
REQ-024 Byte 0x01 at IOCTL_ADDR 0 -> GAME = 0x01, with no PROG_WE.
REQ-025 Byte 0xAB at IOCTL_ADDR 0x11 (o = 1), PROG_RDY returned 3 cycles later -> PROG_WE goes high 2 cycles after the strobe with BA = 0, ADDR = 0, DATA = 0xABAB, MASK = 2'b10. PROG_WE drops the cycle after PROG_RDY.
REQ-026 Bytes at o = 0x080000 and o = 0x100003 -> the first writes BA = 1, ADDR = 0, MASK = 2'b01. The second writes BA = 2, ADDR = 1, MASK = 2'b10.
REQ-027 Four back-to-back IOCTL_WR strobes with PROG_RDY withheld -> the first byte is in the write registers, two bytes are in the FIFO, the fourth byte is dropped and OVERFLOW = 1.
REQ-028 DOWNLOADING falls with 2 bytes queued -> DWNLD_BUSY stays high until the second PROG_RDY, then goes low.
REQ-029 RESET asserted while in WRITE -> the next cycle shows PROG_WE = 0, PROG_MASK = 2'b11 and DWNLD_BUSY = DOWNLOADING.
